// File: rtl/adder_bist.sv
// adder_bist: exhaustive self-test sweep of a 4-bit ripple-carry adder (512 {A,B,C0} vectors).
// Build option ADDER_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module adder_bist #(
    parameter int SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] S,
    input  logic       C4,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       C0,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic       fail_valid,
    output logic [8:0] fail_vec
);

    // state  | meaning
    // IDLE   | waiting for start, outputs at reset values
    // SETTLE | vector driven, down-counter waits for the ripple to resolve
    // CHECK  | single compare of {C4,S} against golden sum
    // DONE   | results held; start begins a new sweep
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [8:0] r_vec;
    logic [3:0] r_cnt;
    logic [9:0] r_err_count;
    logic       r_fail_valid;
    logic [8:0] r_fail_vec;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;

    logic [4:0] w_golden;
    logic       w_mismatch;
    logic [9:0] w_err_next;
    logic       w_last;

    assign w_golden   = {1'b0, r_vec[8:5]} + {1'b0, r_vec[4:1]} + {4'b0, r_vec[0]};
    assign w_mismatch = ({C4, S} != w_golden);
    assign w_err_next = r_err_count + {9'b0, w_mismatch};

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    assign w_last = w_mismatch || (r_vec == 9'h1FF);
`else
    assign w_last = (r_vec == 9'h1FF);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_vec        <= 9'd0;
            r_cnt        <= 4'd0;
            r_err_count  <= 10'd0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 9'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_vec        <= 9'd0;
                        r_cnt        <= SETTLE_LOAD;
                        r_err_count  <= 10'd0;
                        r_fail_valid <= 1'b0;
                        r_fail_vec   <= 9'd0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_CHECK: begin
                    r_err_count <= w_err_next;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_vec   <= r_vec;
                        r_fail_valid <= 1'b1;
                    end
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 10'd0);
                        r_state <= ST_DONE;
                    end else begin
                        r_vec   <= r_vec + 9'd1;
                        r_cnt   <= SETTLE_LOAD;
                        r_state <= ST_SETTLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign A          = r_vec[8:5];
    assign B          = r_vec[4:1];
    assign C0         = r_vec[0];
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign fail_valid = r_fail_valid;
    assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: self-checking bench for adder_bist with a fault-injectable adder model
// and two slow-adder instances (SETTLE_CYCLES 2 and 4).
module tb_adder_bist;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif
    localparam int SET_MAIN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start2, start4;

    logic [3:0] s_m, a_m, b_m;
    logic       c4_m, c0_m, busy_m, done_m, pass_m, fv_m;
    logic [9:0] err_m;
    logic [8:0] fvec_m;

    logic [3:0] s_2, a_2, b_2;
    logic       c4_2, c0_2, busy_2, done_2, pass_2, fv_2;
    logic [9:0] err_2;
    logic [8:0] fvec_2;

    logic [3:0] s_4, a_4, b_4;
    logic       c4_4, c0_4, busy_4, done_4, pass_4, fv_4;
    logic [9:0] err_4;
    logic [8:0] fvec_4;

    adder_bist #(.SETTLE_CYCLES(SET_MAIN)) dut (
        .clk(clk), .rst(rst), .start(start), .S(s_m), .C4(c4_m),
        .A(a_m), .B(b_m), .C0(c0_m), .busy(busy_m), .done(done_m), .pass(pass_m),
        .err_count(err_m), .fail_valid(fv_m), .fail_vec(fvec_m)
    );
    adder_bist #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .S(s_2), .C4(c4_2),
        .A(a_2), .B(b_2), .C0(c0_2), .busy(busy_2), .done(done_2), .pass(pass_2),
        .err_count(err_2), .fail_valid(fv_2), .fail_vec(fvec_2)
    );
    adder_bist #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .S(s_4), .C4(c4_4),
        .A(a_4), .B(b_4), .C0(c0_4), .busy(busy_4), .done(done_4), .pass(pass_4),
        .err_count(err_4), .fail_valid(fv_4), .fail_vec(fvec_4)
    );

    // Main adder: behavioural sum with an optional stuck-at on one bit of {C4,S}
    logic       f_en;
    logic [2:0] f_bit;
    logic       f_val;
    logic [4:0] sum_m;
    always_comb begin
        sum_m = 5'(a_m) + 5'(b_m) + 5'(c0_m);
        if (f_en) sum_m[f_bit] = f_val;
        {c4_m, s_m} = sum_m;
    end

    // Slow adders: result appears three clocks after the operands change
    logic [8:0] p2 [3];
    logic [8:0] p4 [3];
    always_ff @(posedge clk) begin
        p2[0] <= {a_2, b_2, c0_2}; p2[1] <= p2[0]; p2[2] <= p2[1];
        p4[0] <= {a_4, b_4, c0_4}; p4[1] <= p4[0]; p4[2] <= p4[1];
    end
    assign {c4_2, s_2} = 5'(p2[2][8:5]) + 5'(p2[2][4:1]) + 5'(p2[2][0]);
    assign {c4_4, s_4} = 5'(p4[2][8:5]) + 5'(p4[2][4:1]) + 5'(p4[2][0]);

    int errors = 0;
    int checks = 0;

    // Reference: walk all vectors, apply the stuck-at, count mismatches and sweep length
    function automatic void ref_sweep(input bit fen, input int fbit, input bit fval,
                                      input int settle, input bit stop,
                                      output int n_err, output int first, output int len);
        int a, b, c, gold, obs;
        bit halt;
        n_err = 0; first = -1; len = 0; halt = 1'b0;
        for (int v = 0; v < 512; v++) begin
            if (!halt) begin
                a = v / 32; b = (v / 2) % 16; c = v % 2;
                gold = a + b + c;
                obs = gold;
                if (fen) obs = fval ? (obs | (1 << fbit)) : (obs & ~(1 << fbit));
                len += settle + 1;
                if (obs != gold) begin
                    n_err++;
                    if (first < 0) first = v;
                    if (stop) halt = 1'b1;
                end
            end
        end
    endfunction

    // Pulse start, measure busy->done length, and track how long each vector is held
    task automatic do_sweep(input bit noise, output int len, output bit to,
                            output int good_runs, output logic [8:0] last_vec);
        logic [8:0] prev, cur;
        int runlen;
        bit fin;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if (busy_m !== 1'b1) begin
            errors++; $display("FAIL busy_rise: busy=%b required 1", busy_m);
        end
        prev = {a_m, b_m, c0_m};
        checks++;
        if (prev !== 9'd0) begin
            errors++; $display("FAIL first_vec: vec=%h required 000", prev);
        end
        runlen = 1; len = 0; to = 1'b0; fin = 1'b0; good_runs = 0;
        while (!fin && !to) begin
            @(negedge clk);
            len++;
            cur = {a_m, b_m, c0_m};
            if (done_m) begin
                fin = 1'b1;
                start = 1'b0;
            end else begin
                if (cur == prev) runlen++;
                else begin
                    if (runlen == SET_MAIN + 1 && cur == prev + 9'd1) good_runs++;
                    prev = cur; runlen = 1;
                end
                if (noise) start = ($urandom_range(0, 3) == 0);
                if (len > 4200) to = 1'b1;
            end
        end
        start = 1'b0;
        if (runlen == SET_MAIN + 1) good_runs++;
        last_vec = prev;
        checks++;
        if (to) begin
            errors++; $display("FAIL sweep_timeout: done=%b after %0d cycles required 1", done_m, len);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0; start4 = 1'b0;
        f_en = 1'b0; f_bit = 3'd0; f_val = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (a_m !== 4'd0) begin errors++; $display("FAIL rst_A: %h required 0", a_m); end
        checks++; if (b_m !== 4'd0) begin errors++; $display("FAIL rst_B: %h required 0", b_m); end
        checks++; if (c0_m !== 1'b0) begin errors++; $display("FAIL rst_C0: %b required 0", c0_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL rst_busy: %b required 0", busy_m); end
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL rst_done: %b required 0", done_m); end
        checks++; if (pass_m !== 1'b0) begin errors++; $display("FAIL rst_pass: %b required 0", pass_m); end
        checks++; if (err_m !== 10'd0) begin errors++; $display("FAIL rst_err: %0d required 0", err_m); end
        checks++; if (fv_m !== 1'b0) begin errors++; $display("FAIL rst_fail_valid: %b required 0", fv_m); end
        checks++; if (fvec_m !== 9'd0) begin errors++; $display("FAIL rst_fail_vec: %h required 0", fvec_m); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_m !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy=%b required 0", busy_m); end
    endtask

    task automatic test_clean_sweep();
        int len, runs;
        bit to;
        logic [8:0] last;
        f_en = 1'b0;
        do_sweep(1'b0, len, to, runs, last);
        checks++; if (len != 512 * (SET_MAIN + 1)) begin errors++; $display("FAIL clean_len: %0d required %0d", len, 512 * (SET_MAIN + 1)); end
        checks++; if (pass_m !== 1'b1) begin errors++; $display("FAIL clean_pass: %b required 1", pass_m); end
        checks++; if (err_m !== 10'd0) begin errors++; $display("FAIL clean_err: %0d required 0", err_m); end
        checks++; if (fv_m !== 1'b0) begin errors++; $display("FAIL clean_fail_valid: %b required 0", fv_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL clean_busy_done: %b required 0", busy_m); end
        checks++; if (runs != 512) begin errors++; $display("FAIL vec_hold_runs: %0d good runs required 512", runs); end
        checks++; if (last !== 9'h1FF) begin errors++; $display("FAIL last_vec: %h required 1ff", last); end
        repeat (5) @(negedge clk);
        checks++;
        if ({a_m, b_m, c0_m, done_m} !== 10'h3FF) begin
            errors++; $display("FAIL done_hold: A=%h B=%h C0=%b done=%b required f f 1 1", a_m, b_m, c0_m, done_m);
        end
    endtask

    task automatic run_fault(input string name, input logic [2:0] bitn, input logic val);
        int len, runs, x_err, x_first, x_len;
        bit to;
        logic [8:0] last;
        f_en = 1'b1; f_bit = bitn; f_val = val;
        ref_sweep(1'b1, int'(bitn), val, SET_MAIN, STOP_EN, x_err, x_first, x_len);
        do_sweep(1'b0, len, to, runs, last);
        checks++; if (int'(err_m) != x_err) begin errors++; $display("FAIL %s_err: %0d required %0d", name, err_m, x_err); end
        checks++; if (pass_m !== (x_err == 0)) begin errors++; $display("FAIL %s_pass: %b required %0d", name, pass_m, x_err == 0); end
        checks++; if (fv_m !== (x_first >= 0)) begin errors++; $display("FAIL %s_fail_valid: %b required %0d", name, fv_m, x_first >= 0); end
        checks++; if (int'(fvec_m) != x_first) begin errors++; $display("FAIL %s_fail_vec: %h required %h", name, fvec_m, x_first); end
        checks++; if (len != x_len) begin errors++; $display("FAIL %s_len: %0d required %0d", name, len, x_len); end
    endtask

    task automatic test_stuck_s0();
        run_fault("s0_stuck0", 3'd0, 1'b0);
        checks++;
        if (err_m !== (STOP_EN ? 10'd1 : 10'd256) || fvec_m !== 9'h001) begin
            errors++; $display("FAIL s0_stuck0_fixed: err=%0d vec=%h required %0d 001", err_m, fvec_m, STOP_EN ? 1 : 256);
        end
    endtask

    task automatic test_random_faults();
        for (int i = 0; i < 3; i++) begin
            run_fault("rand_fault", 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_restart_in_done();
        int cyc;
        f_en = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if ({done_m, busy_m, err_m, fv_m} !== {1'b0, 1'b1, 10'd0, 1'b0}) begin
            errors++; $display("FAIL restart_clear: done=%b busy=%b err=%0d fv=%b required 0 1 0 0", done_m, busy_m, err_m, fv_m);
        end
        cyc = 0;
        while (!done_m && cyc < 4200) begin @(negedge clk); cyc++; end
        checks++;
        if (done_m !== 1'b1 || pass_m !== 1'b1 || cyc != 512 * (SET_MAIN + 1)) begin
            errors++; $display("FAIL restart_sweep: done=%b pass=%b len=%0d required 1 1 %0d", done_m, pass_m, cyc, 512 * (SET_MAIN + 1));
        end
    endtask

    task automatic test_start_ignored();
        int len, runs;
        bit to;
        logic [8:0] last;
        f_en = 1'b0;
        do_sweep(1'b1, len, to, runs, last);
        checks++; if (len != 512 * (SET_MAIN + 1)) begin errors++; $display("FAIL noisy_start_len: %0d required %0d", len, 512 * (SET_MAIN + 1)); end
        checks++; if (runs != 512) begin errors++; $display("FAIL noisy_start_runs: %0d required 512", runs); end
    endtask

    task automatic test_reset_mid();
        int len, runs, k;
        bit to;
        logic [8:0] last;
        f_en = 1'b1; f_bit = 3'd4; f_val = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 1000 + $urandom_range(0, 7);
        repeat (k - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({a_m, b_m, c0_m, busy_m, done_m, pass_m, err_m, fv_m, fvec_m} !== 32'd0) begin
            errors++; $display("FAIL mid_reset: A=%h B=%h C0=%b busy=%b done=%b err=%0d fv=%b required all 0",
                               a_m, b_m, c0_m, busy_m, done_m, err_m, fv_m);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy_m !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: busy=%b required 0", busy_m); end
        f_en = 1'b0;
        do_sweep(1'b0, len, to, runs, last);
        checks++;
        if (len != 512 * (SET_MAIN + 1) || pass_m !== 1'b1 || err_m !== 10'd0) begin
            errors++; $display("FAIL post_reset_sweep: len=%0d pass=%b err=%0d required %0d 1 0", len, pass_m, err_m, 512 * (SET_MAIN + 1));
        end
    endtask

    task automatic test_settle_delay();
        int cyc;
        @(negedge clk) begin start2 = 1'b1; start4 = 1'b1; end
        @(negedge clk) begin start2 = 1'b0; start4 = 1'b0; end
        cyc = 0;
        while (!(done_2 && done_4) && cyc < 3000) begin @(negedge clk); cyc++; end
        checks++; if (done_2 !== 1'b1 || done_4 !== 1'b1) begin errors++; $display("FAIL slow_done: done2=%b done4=%b required 1 1", done_2, done_4); end
        checks++; if (err_2 == 10'd0 || pass_2 !== 1'b0) begin errors++; $display("FAIL slow_settle2: err=%0d pass=%b required >0 0", err_2, pass_2); end
        checks++; if (fv_2 !== 1'b1 || fvec_2 !== 9'h001) begin errors++; $display("FAIL slow_settle2_vec: fv=%b vec=%h required 1 001", fv_2, fvec_2); end
        checks++; if (pass_4 !== 1'b1 || err_4 !== 10'd0 || fv_4 !== 1'b0 || fvec_4 !== 9'd0) begin
            errors++; $display("FAIL slow_settle4: pass=%b err=%0d fv=%b vec=%h required 1 0 0 0", pass_4, err_4, fv_4, fvec_4);
        end
        checks++; if (busy_2 !== 1'b0 || busy_4 !== 1'b0) begin errors++; $display("FAIL slow_busy: %b %b required 0 0", busy_2, busy_4); end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_stuck_s0();
        test_restart_in_done();
        test_random_faults();
        test_start_ignored();
        test_reset_mid();
        test_settle_delay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
